// File: rtl/vga_out_stage.sv
// Two-stage registered VGA output: delay-matches sync/visible to colour, blanks
// outside the visible area, applies sync polarity and offers a frame-latched test pattern.
module vga_out_stage #(
  parameter int unsigned BAR_WIDTH = 80,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] rgb_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       visible_in,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic [1:0] test_mode,
  input  logic [5:0] solid_rgb,
  output logic [5:0] rgb_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [7:0] frame_count,
  output logic [1:0] mode_active
);

  localparam int PXW = $clog2(BAR_WIDTH + 1);

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  // Stage 1
  logic [5:0]     rgb_s1_q, rgb_s1_d;
  logic           hsync_s1_q, hsync_s1_d;
  logic           vsync_s1_q, vsync_s1_d;
  logic           vis_s1_q, vis_s1_d;
  logic [5:0]     pat_s1_q, pat_s1_d;
  logic           vsync_hist_q, vsync_hist_d;
  // Stage 2
  logic [5:0]     rgb_out_q, rgb_out_d;
  logic           hsync_out_q, hsync_out_d;
  logic           vsync_out_q, vsync_out_d;
  // Frame / pattern state
  logic [7:0]     frame_count_q, frame_count_d;
  mode_e          mode_q, mode_d;
  logic [PXW-1:0] bar_px_q, bar_px_d;
  logic [2:0]     bar_idx_q, bar_idx_d;

  logic           frame_edge;
  logic [2:0]     pix_bar_idx;
  logic [PXW-1:0] px_inc;
  logic           unused_vpos_bits;

  assign unused_vpos_bits = ^{vpos[9:6], vpos[4:0]};
  assign frame_edge       = vsync_in & ~vsync_hist_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bar_px_d      = bar_px_q;
    bar_idx_d     = bar_idx_q;
    pix_bar_idx   = bar_idx_q;
    px_inc        = bar_px_q + PXW'(1);
    frame_count_d = frame_count_q;
    mode_d        = mode_q;
    pat_s1_d      = 6'h00;

    // Column 0 restarts the bars; the counters then track min(h/BAR_WIDTH, 7).
    if (hpos == 10'd0) begin
      pix_bar_idx = 3'd0;
      bar_px_d    = PXW'(1);
      bar_idx_d   = 3'd0;
    end else if (px_inc == PXW'(BAR_WIDTH)) begin
      bar_px_d  = '0;
      bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
    end else begin
      bar_px_d = px_inc;
    end

    if (frame_edge) begin
      frame_count_d = frame_count_q + 8'd1;
      mode_d        = mode_e'(test_mode);
    end

    unique case (mode_q)
      MODE_BARS:    pat_s1_d = {{2{pix_bar_idx[2]}}, {2{pix_bar_idx[1]}}, {2{pix_bar_idx[0]}}};
      MODE_CHECKER: pat_s1_d = (hpos[5] ^ vpos[5] ^ frame_count_q[0]) ? 6'h3F : 6'h00;
      MODE_SOLID:   pat_s1_d = solid_rgb;
      default:      pat_s1_d = 6'h00;
    endcase

    rgb_s1_d     = rgb_in;
    hsync_s1_d   = hsync_in;
    vsync_s1_d   = vsync_in;
    vis_s1_d     = visible_in;
    vsync_hist_d = vsync_in;

    if (!vis_s1_q)               rgb_out_d = 6'h00;
    else if (mode_q == MODE_PASS) rgb_out_d = rgb_s1_q;
    else                          rgb_out_d = pat_s1_q;

    hsync_out_d = hsync_s1_q ~^ HSYNC_POL;
    vsync_out_d = vsync_s1_q ~^ VSYNC_POL;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_s1_q      <= '0;
      hsync_s1_q    <= 1'b0;
      vsync_s1_q    <= 1'b0;
      vis_s1_q      <= 1'b0;
      pat_s1_q      <= '0;
      vsync_hist_q  <= 1'b0;
      rgb_out_q     <= '0;
      hsync_out_q   <= ~HSYNC_POL;
      vsync_out_q   <= ~VSYNC_POL;
      frame_count_q <= '0;
      mode_q        <= MODE_PASS;
      bar_px_q      <= '0;
      bar_idx_q     <= '0;
    end else begin
      rgb_s1_q      <= rgb_s1_d;
      hsync_s1_q    <= hsync_s1_d;
      vsync_s1_q    <= vsync_s1_d;
      vis_s1_q      <= vis_s1_d;
      pat_s1_q      <= pat_s1_d;
      vsync_hist_q  <= vsync_hist_d;
      rgb_out_q     <= rgb_out_d;
      hsync_out_q   <= hsync_out_d;
      vsync_out_q   <= vsync_out_d;
      frame_count_q <= frame_count_d;
      mode_q        <= mode_d;
      bar_px_q      <= bar_px_d;
      bar_idx_q     <= bar_idx_d;
    end
  end

  assign rgb_out     = rgb_out_q;
  assign hsync_out   = hsync_out_q;
  assign vsync_out   = vsync_out_q;
  assign frame_count = frame_count_q;
  assign mode_active = mode_q;

endmodule

// File: tb/tb_vga_out_stage.sv
// Directed bench for vga_out_stage: latency, sync polarity, blanking, frame-latched
// test modes, frame counter wrap and mid-frame reset.
module tb_vga_out_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] rgb_in;
  logic       hsync_in, vsync_in, visible_in;
  logic [9:0] hpos, vpos;
  logic [1:0] test_mode;
  logic [5:0] solid_rgb;
  logic [5:0] rgb_out;
  logic       hsync_out, vsync_out;
  logic [7:0] frame_count;
  logic [1:0] mode_active;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_fc;
  logic [5:0] bar_tab [8] = '{6'h00, 6'h03, 6'h0C, 6'h0F, 6'h30, 6'h33, 6'h3C, 6'h3F};

  vga_out_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rgb_in     (rgb_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .visible_in (visible_in),
    .hpos       (hpos),
    .vpos       (vpos),
    .test_mode  (test_mode),
    .solid_rgb  (solid_rgb),
    .rgb_out    (rgb_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_count(frame_count),
    .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_edge(input logic [1:0] m);
    test_mode  = m;
    visible_in = 1'b0;
    vsync_in   = 1'b1;
    tick();
    vsync_in = 1'b0;
    tick();
    exp_fc = exp_fc + 8'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks += 5;
    if (rgb_out !== 6'h00) begin errors++; $display("FAIL reset_rgb got %h want 00", rgb_out); end
    if (hsync_out !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hsync_out); end
    if (vsync_out !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vsync_out); end
    if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_fc got %0d want 0", frame_count); end
    if (mode_active !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode_active); end
    exp_fc = 8'd0;
  endtask

  task automatic test_latency();
    rst_n      = 1'b1;
    visible_in = 1'b1;
    rgb_in     = 6'h2A;
    tick();
    rgb_in = 6'h00;
    checks++;
    if (rgb_out !== 6'h00) begin errors++; $display("FAIL lat_n1 got %h want 00", rgb_out); end
    tick();
    checks++;
    if (rgb_out !== 6'h2A) begin errors++; $display("FAIL lat_n2 got %h want 2a", rgb_out); end
    tick();
    checks++;
    if (rgb_out !== 6'h00) begin errors++; $display("FAIL lat_n3 got %h want 00", rgb_out); end
  endtask

  task automatic test_hsync();
    int first = -1;
    int cnt   = 0;
    for (int i = 0; i < 100; i++) begin
      hsync_in = (i < 96);
      tick();
      if (hsync_out === 1'b0) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    checks += 3;
    if (cnt != 96) begin errors++; $display("FAIL hsync_width got %0d want 96", cnt); end
    if (first != 1) begin errors++; $display("FAIL hsync_start got %0d want 1", first); end
    if (hsync_out !== 1'b1) begin errors++; $display("FAIL hsync_idle got %b want 1", hsync_out); end
  endtask

  task automatic test_blank();
    solid_rgb = 6'h15;
    for (int m = 0; m < 4; m++) begin
      frame_edge(2'(m));
      visible_in = 1'b0;
      rgb_in     = 6'h3F;
      hpos       = 10'd0;
      vpos       = 10'd0;
      for (int k = 0; k < 3; k++) begin
        tick();
        checks++;
        if (rgb_out !== 6'h00) begin errors++; $display("FAIL blank_m%0d got %h want 00", m, rgb_out); end
      end
      checks++;
      if (mode_active !== 2'(m)) begin errors++; $display("FAIL blank_mode got %0d want %0d", mode_active, m); end
    end
  endtask

  task automatic test_mode_latch();
    frame_edge(2'd0);
    test_mode  = 2'd1;
    visible_in = 1'b1;
    rgb_in     = 6'h15;
    hpos       = 10'd300;
    repeat (3) tick();
    checks += 2;
    if (mode_active !== 2'd0) begin errors++; $display("FAIL latch_hold_mode got %0d want 0", mode_active); end
    if (rgb_out !== 6'h15) begin errors++; $display("FAIL latch_hold_rgb got %h want 15", rgb_out); end
    frame_edge(2'd1);
    checks++;
    if (mode_active !== 2'd1) begin errors++; $display("FAIL latch_new_mode got %0d want 1", mode_active); end
    vpos = 10'd1;
    for (int h = 0; h <= 640; h++) begin
      if (h < 640) begin
        hpos       = 10'(h);
        visible_in = 1'b1;
      end else begin
        visible_in = 1'b0;
      end
      tick();
      if (h >= 1) begin
        checks++;
        if (rgb_out !== bar_tab[(h - 1) / 80]) begin
          errors++;
          $display("FAIL bars_h%0d got %h want %h", h - 1, rgb_out, bar_tab[(h - 1) / 80]);
        end
      end
    end
  endtask

  task automatic test_frames();
    logic [5:0] exp_px;
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    exp_fc = 8'd0;
    for (int f = 0; f < 256; f++) begin
      frame_edge(2'd2);
      checks++;
      if (frame_count !== exp_fc) begin errors++; $display("FAIL fc_f%0d got %0d want %0d", f, frame_count, exp_fc); end
      hpos       = 10'd0;
      vpos       = 10'd0;
      visible_in = 1'b1;
      tick();
      visible_in = 1'b0;
      tick();
      exp_px = ((f + 1) % 2 == 1) ? 6'h3F : 6'h00;
      checks++;
      if (rgb_out !== exp_px) begin errors++; $display("FAIL checker_f%0d got %h want %h", f, rgb_out, exp_px); end
    end
    checks++;
    if (frame_count !== 8'd0) begin errors++; $display("FAIL fc_wrap got %0d want 0", frame_count); end
  endtask

  task automatic test_reset_mid();
    for (int f = 0; f < 10; f++) frame_edge(2'd1);
    vpos     = 10'd20;
    hsync_in = 1'b1;
    for (int h = 0; h <= 105; h++) begin
      hpos       = 10'(h);
      visible_in = 1'b1;
      tick();
    end
    checks += 2;
    if (rgb_out !== 6'h03) begin errors++; $display("FAIL pre_rst_rgb got %h want 03", rgb_out); end
    if (hsync_out !== 1'b0) begin errors++; $display("FAIL pre_rst_hsync got %b want 0", hsync_out); end
    rst_n = 1'b0;
    tick();
    checks += 5;
    if (frame_count !== 8'd0) begin errors++; $display("FAIL mid_rst_fc got %0d want 0", frame_count); end
    if (mode_active !== 2'd0) begin errors++; $display("FAIL mid_rst_mode got %0d want 0", mode_active); end
    if (rgb_out !== 6'h00) begin errors++; $display("FAIL mid_rst_rgb got %h want 00", rgb_out); end
    if (hsync_out !== 1'b1) begin errors++; $display("FAIL mid_rst_hsync got %b want 1", hsync_out); end
    if (vsync_out !== 1'b1) begin errors++; $display("FAIL mid_rst_vsync got %b want 1", vsync_out); end
    rst_n    = 1'b1;
    hsync_in = 1'b0;
    rgb_in   = 6'h1B;
    tick();
    checks++;
    if (rgb_out !== 6'h00) begin errors++; $display("FAIL post_rst_n1 got %h want 00", rgb_out); end
    tick();
    checks++;
    if (rgb_out !== 6'h1B) begin errors++; $display("FAIL post_rst_n2 got %h want 1b", rgb_out); end
  endtask

  initial begin
    rst_n      = 1'b0;
    rgb_in     = '0;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    visible_in = 1'b0;
    hpos       = '0;
    vpos       = '0;
    test_mode  = 2'd0;
    solid_rgb  = '0;
    exp_fc     = '0;
    test_reset();
    test_latency();
    test_hsync();
    test_blank();
    test_mode_latch();
    test_frames();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_out_stage.md
Name: vga_out_stage

Overview:
- Registered output stage directly downstream of the pixel colour mux.
- Takes the mux's 6-bit colour, plus the raw sync, visible and position signals from the VGA timing generator.
- Delay-matches sync and visible to the colour, forces black outside the visible area, and applies output sync polarity.
- Provides a frame-synchronised test-pattern override for bring-up: colour bars, animated checker, solid colour.

Parameters:
- BAR_WIDTH, 80: pixels per colour bar in bars mode.
- HSYNC_POL, 0: output hsync active level (0 = active-low).
- VSYNC_POL, 0: output vsync active level (0 = active-low).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- rgb_in  in  6  colour from mux, {r[1:0],g[1:0],b[1:0]} at bits [5:4],[3:2],[1:0].
- hsync_in  in  1  raw hsync, active-high.
- vsync_in  in  1  raw vsync, active-high.
- visible_in  in  1  high in the visible area.
- hpos  in  10  current pixel column; increments by 1 per clk along a line.
- vpos  in  10  current line.
- test_mode  in  2  requested mode: 0 pass, 1 bars, 2 checker, 3 solid.
- solid_rgb  in  6  colour used in mode 3.
- rgb_out  out  6  registered pixel colour.
- hsync_out  out  1  registered hsync at HSYNC_POL.
- vsync_out  out  1  registered vsync at VSYNC_POL.
- frame_count  out  8  frames elapsed.
- mode_active  out  2  mode currently applied.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge) clears all state:
  - rgb_out=0, frame_count=0, mode_active=0.
  - Pipeline visible flags=0, bar counters=0, vsync history=0.
  - hsync_out=~HSYNC_POL and vsync_out=~VSYNC_POL, i.e. inactive.
- Reset mid-frame takes effect at that edge. The first two post-reset cycles output black with inactive syncs.
- Latency: exactly 2 clks for all outputs. rgb_out, hsync_out and vsync_out at cycle n+2 reflect the inputs at cycle n.
- Stage 1 registers: rgb_in, hsync_in, vsync_in, visible_in, the computed pattern colour, and the vsync history bit.
- Stage 2 output rules:
  - Blanking: rgb_out=0 if stage-1 visible=0, regardless of mode.
  - Otherwise rgb_out = stage-1 rgb if mode_active=0, else the stage-1 pattern colour.
- Sync outputs: hsync_out = stage-1 hsync XNOR HSYNC_POL; vsync_out likewise with VSYNC_POL.
- Frame edge: vsync_in=1 while its registered history=0.
  - At that edge, frame_count increments, wrapping 255->0.
  - At the same edge, mode_active <= test_mode.
- test_mode changes at any other time have no effect until the next frame edge. Simultaneous frame edge and test_mode change latches the new value.
- Bars counters (bar_px 0..BAR_WIDTH-1, bar_idx 0..7):
  - When hpos==0: next bar_px=1, and the pixel uses bar_idx=0.
  - Otherwise bar_px increments. When it reaches BAR_WIDTH it resets to 0 and bar_idx increments, saturating at 7.
  - Net effect: bar index for column h = min(h/BAR_WIDTH, 7).
- Bar colour for index i: each channel pair = {i[k],i[k]}, with red=i[2], green=i[1], blue=i[0].
  - Index 0 is black, 7 is white (6'b111111).
- Checker: c = hpos[5]^vpos[5]^frame_count[0]; colour = c ? 6'b111111 : 6'b000000. The checker inverts every frame.
- Solid: colour = solid_rgb, sampled in stage 1 (no frame latching).
- Counters run in all modes; the mode affects output selection only.

Test Plan:
- Reset, then pass mode with visible=1, rgb_in=6'h2A held one clk at cycle n -> rgb_out=6'h2A at n+2, never at n+1.
- hsync_in pulse 1 for 96 clks, default params -> hsync_out low for exactly 96 clks, starting 2 clks after the input edge; high otherwise and after reset.
- visible_in=0 with rgb_in=6'h3F in modes 0-3 -> rgb_out=0 throughout.
- test_mode=1 set mid-frame -> output unchanged until the next vsync rising edge, then mode_active=1.
  - Next line, hpos 0..639 -> rgb_out 00 (h0-79), 03, 0C, 0F, 30, 33, 3C, 3F (h560-639); each value held 80 clks.
- Run 256 vsync pulses -> frame_count counts 0..255 and returns to 0.
  - In mode 2, pixel (0,0) alternates 00/3F on successive frames.
- Assert rst_n=0 mid-line in mode 1 after 10 frames -> next clk: frame_count=0, mode_active=0, rgb_out=0, syncs inactive.
  - Pass-through resumes with 2-clk latency.
